// File: rtl/regfile_dump_seq_pkg.sv
// Shared encodings for the register file dump/clear sequencer.
package regfile_dump_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RD    = 3'd2,
    S_CAP   = 3'd3,
    S_EMIT0 = 3'd4,
    S_EMIT1 = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic MODE_DUMP  = 1'b0;
  localparam logic MODE_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_dump_seq.sv
// Drives the register file ports to either clear every entry or stream all
// entries out, two at a time, over a valid/ready interface.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; register file ports not in use
// S_CLEAR | writing CLEAR_VALUE to address clr_cnt, one per cycle
// S_RD    | presenting read addresses 2p / 2p+1
// S_CAP   | holding addresses; read data captured into buf0/buf1
// S_EMIT0 | offering buf0 (index 2p) to the sink
// S_EMIT1 | offering buf1 (index 2p+1) to the sink
// S_FIN   | one-cycle done pulse
module regfile_dump_seq
  import regfile_dump_seq_pkg::*;
#(
  parameter int                 WIDTH       = 32,
  parameter int                 DEPTH       = 32,
  parameter int                 AW          = 5,
  parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             rf_wr,
  output logic [AW-1:0]    rf_r1,
  output logic [AW-1:0]    rf_r2,
  output logic [AW-1:0]    rf_rw,
  output logic [WIDTH-1:0] rf_din,
  input  logic [WIDTH-1:0] rf_out1,
  input  logic [WIDTH-1:0] rf_out2,
  output logic [WIDTH-1:0] dout,
  output logic [AW-1:0]    dout_idx,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-2:0] LAST_P    = (AW-1)'(DEPTH / 2 - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    clr_cnt, clr_cnt_nxt;
  logic [AW-2:0]    p, p_nxt;
  logic [WIDTH-1:0] buf0, buf1;
  logic [AW-1:0]    rw_q;
  logic [WIDTH-1:0] din_q;
  logic [AW-1:0]    addr_even, addr_odd;

  assign addr_even = {p, 1'b0};
  assign addr_odd  = {p, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      p       <= '0;
      buf0    <= '0;
      buf1    <= '0;
      rw_q    <= '0;
      din_q   <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      p       <= p_nxt;
      if (state == S_CAP) begin
        buf0 <= rf_out1;
        buf1 <= rf_out2;
      end
      // write address/data keep their last driven value once the clear ends
      if (state == S_CLEAR) begin
        rw_q  <= clr_cnt;
        din_q <= CLEAR_VALUE;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    p_nxt       = p;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_CLEAR) begin
            state_nxt   = S_CLEAR;
            clr_cnt_nxt = '0;
          end else begin
            state_nxt = S_RD;
            p_nxt     = '0;
          end
        end
      end
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) state_nxt = S_FIN;
      end
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = S_EMIT0;
      S_EMIT0: if (dout_ready) state_nxt = S_EMIT1;
      S_EMIT1: begin
        if (dout_ready) begin
          if (p == LAST_P) begin
            state_nxt = S_FIN;
          end else begin
            p_nxt     = p + 1'b1;
            state_nxt = S_RD;
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_FIN);
    rf_wr      = (state == S_CLEAR);
    rf_rw      = rf_wr ? clr_cnt : rw_q;
    rf_din     = rf_wr ? CLEAR_VALUE : din_q;
    rf_r1      = '0;
    rf_r2      = '0;
    dout       = '0;
    dout_idx   = '0;
    dout_valid = 1'b0;
    case (state)
      S_RD, S_CAP: begin
        rf_r1 = addr_even;
        rf_r2 = addr_odd;
      end
      S_EMIT0: begin
        dout_valid = 1'b1;
        dout       = buf0;
        dout_idx   = addr_even;
      end
      S_EMIT1: begin
        dout_valid = 1'b1;
        dout       = buf1;
        dout_idx   = addr_odd;
      end
      default: ;
    endcase
  end

endmodule
